vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences the pixel-colour datapath (stripe/pattern generators) for 640x480@60Hz VGA.
//  Divides the system clock to a pixel-rate enable and runs horizontal/vertical counters.
//  Drives hc, vc, vidon to the pattern generators and hsync/vsync to the connector.
//  Emits line_start/frame_start strobes so downstream blocks update only at safe boundaries.
// PARAMETERS
//  CLK_DIV  2    sys clocks per pixel (>=1); 2 gives 25 MHz from 50 MHz
//  HPIXELS  800  pixel periods per line
//  VLINES   521  lines per frame
//  HSP      128  hsync pulse width, pixels (hc 0..HSP-1)
//  HBP      144  first visible hc
//  HFP      784  first non-visible hc after the active region
//  VSP      2    vsync pulse width, lines (vc 0..VSP-1)
//  VBP      31   first visible vc
//  VFP      511  first non-visible vc after the active region
// PORTS
//  clk          in   1   system clock; the only clock
//  rst_n        in   1   synchronous reset, active low
//  en           in   1   run enable; low freezes the timing
//  pix_en       out  1   pixel-rate enable, 1 sys clk wide
//  hc           out  10  horizontal count, 0..HPIXELS-1
//  vc           out  10  vertical count, 0..VLINES-1
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  vidon        out  1   1 inside the visible window
//  line_start   out  1   1-clk pulse when hc wraps to 0
//  frame_start  out  1   1-clk pulse when (hc,vc) wraps to (0,0)
// BEHAVIOUR
//  Reset: rst_n sampled low at a clk edge -> div_cnt=0, hc=0, vc=0, hsync=0, vsync=0,
//   vidon=0, line_start=0, frame_start=0. Reset overrides en. Reset mid-frame restarts at (0,0).
//   Reset does not pulse frame_start.
//  Divider: div_cnt runs 0..CLK_DIV-1. pix_en = en & (div_cnt==CLK_DIV-1), decoded from the
//   register. At an edge with pix_en=1, div_cnt is loaded with 0; otherwise, if en=1, it
//   increments. The first pix_en is in cycle CLK_DIV after reset release. CLK_DIV=1 -> pix_en=en.
//  Counters advance only at edges with pix_en=1:
//   - hc==HPIXELS-1 -> hc=0 and the line advances; else hc+1.
//   - On a line advance: vc==VLINES-1 -> vc=0; else vc+1.
//  Decode is registered and computed from the next-state counter values, so hsync, vsync
//   and vidon change in the same clk as hc/vc (zero skew):
//   - hsync = !(hc_n < HSP)
//   - vsync = !(vc_n < VSP)
//   - vidon = (HBP <= hc_n < HFP) && (VBP <= vc_n < VFP)
//  line_start: 1 for exactly the clk in which hc has just wrapped to 0; 0 otherwise.
//  frame_start: same, for the wrap to (0,0). It coincides with a line_start.
//  en=0: pix_en=0; div_cnt, hc, vc and all decodes hold; strobes are 0.
//   en=1 resumes from the held div_cnt with no phase loss.
//  Widths: counters are 10-bit unsigned, with no overflow for the defaults (max 799).
//   Wrap is by compare only; there is no modulo arithmetic.
//  Period: one frame = HPIXELS*VLINES*CLK_DIV clks = 833600 at the defaults.
// TESTING
//  T1 reset: hold rst_n=0 for 3 clks with en=1 -> hc=0, vc=0, hsync=0, vsync=0, vidon=0,
//     strobes 0, pix_en=0.
//  T2 divider: CLK_DIV=2, en=1 -> pix_en high in cycles 2,4,6... after release;
//     hc=1 after cycle 2, hc=2 after cycle 4.
//  T3 line: hsync=0 for hc 0..127 and 1 at hc=128. With vc=31, vidon rises with hc=144
//     and falls with hc=784.
//  T4 line wrap: hc=799, vc=40, pix_en -> hc=0, vc=41, line_start=1 for 1 clk,
//     frame_start=0.
//  T5 frame wrap: hc=799, vc=520 -> (0,0), frame_start=1 and line_start=1 for 1 clk,
//     vsync=0. Frame period = 833600 clks.
//  T6 en/reset mid-op: en=0 at hc=300 for 10 clks -> hc holds and pix_en=0; resume with
//     the same phase. Then rst_n=0 at vc=200 -> (0,0) on the next edge, no frame_start.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// 640x480@60Hz VGA timing: pixel-rate enable, h/v counters, zero-skew registered sync/blank decode.
// Sync, vidon and the line/frame strobes are registered from next-state counts so they align with hc/vc.
module vga_timing_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HSP     = 128,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VSP     = 2,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       line_start,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] HSP_C  = 10'(HSP);
  localparam logic [9:0] HBP_C  = 10'(HBP);
  localparam logic [9:0] HFP_C  = 10'(HFP);
  localparam logic [9:0] VSP_C  = 10'(VSP);
  localparam logic [9:0] VBP_C  = 10'(VBP);
  localparam logic [9:0] VFP_C  = 10'(VFP);

  logic [DW-1:0] div_cnt;
  logic [9:0]    hc_n;
  logic [9:0]    vc_n;
  logic          h_wrap;
  logic          v_wrap;

  assign pix_en = en & (div_cnt == DIV_MAX);

  always_comb begin
    hc_n   = hc;
    vc_n   = vc;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_en) begin
      if (hc == H_LAST) begin
        hc_n   = 10'd0;
        h_wrap = 1'b1;
        if (vc == V_LAST) begin
          vc_n   = 10'd0;
          v_wrap = 1'b1;
        end else begin
          vc_n = vc + 10'd1;
        end
      end else begin
        hc_n = hc + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      hc          <= 10'd0;
      vc          <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vidon       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (pix_en) begin
        div_cnt <= '0;
      end else if (en) begin
        div_cnt <= div_cnt + 1'b1;
      end
      hc    <= hc_n;
      vc    <= vc_n;
      // Decoding hc_n/vc_n (not hc/vc) keeps sync and blanking in step with the counters.
      hsync <= !(hc_n < HSP_C);
      vsync <= !(vc_n < VSP_C);
      vidon <= (hc_n >= HBP_C) && (hc_n < HFP_C) && (vc_n >= VBP_C) && (vc_n < VFP_C);
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboarded bench: default-timing instance plus a shrunken instance so full frames fit the run.
module tb_vga_timing_ctrl;

  localparam int P_DIV[2] = '{2, 3};
  localparam int P_H[2]   = '{800, 20};
  localparam int P_V[2]   = '{521, 10};
  localparam int P_HSP[2] = '{128, 3};
  localparam int P_HBP[2] = '{144, 5};
  localparam int P_HFP[2] = '{784, 17};
  localparam int P_VSP[2] = '{2, 2};
  localparam int P_VBP[2] = '{31, 3};
  localparam int P_VFP[2] = '{511, 8};
  localparam int SMALL_FRAME = 20 * 10 * 3;
  localparam int LIMIT = 90000;

  logic clk = 1'b0;
  logic rst_n, en;
  logic       pix_en, hsync, vsync, vidon, line_start, frame_start;
  logic [9:0] hc, vc;
  logic       pix_en_s, hsync_s, vsync_s, vidon_s, line_start_s, frame_start_s;
  logic [9:0] hc_s, vc_s;

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix_en), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .vidon(vidon),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_ctrl #(
    .CLK_DIV(3), .HPIXELS(20), .VLINES(10), .HSP(3), .HBP(5), .HFP(17),
    .VSP(2), .VBP(3), .VFP(8)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix_en_s), .hc(hc_s), .vc(vc_s),
    .hsync(hsync_s), .vsync(vsync_s), .vidon(vidon_s),
    .line_start(line_start_s), .frame_start(frame_start_s)
  );

  int n_chk = 0;
  int n_err = 0;
  int ncyc  = 0;
  bit started = 1'b0;

  int m_div[2], m_hc[2], m_vc[2];
  bit m_hs[2], m_vs[2], m_vid[2], m_ls[2], m_fs[2];
  logic [24:0] q0[$];
  logic [24:0] q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic e);
    int nh, nv;
    bit pe, lw;
    logic [24:0] v;
    if (!r) begin
      m_div[k] = 0; m_hc[k] = 0; m_vc[k] = 0;
      m_hs[k] = 0; m_vs[k] = 0; m_vid[k] = 0; m_ls[k] = 0; m_fs[k] = 0;
    end else begin
      pe = e && (m_div[k] == P_DIV[k] - 1);
      nh = m_hc[k];
      nv = m_vc[k];
      lw = 0;
      if (pe) begin
        m_div[k] = 0;
        if (nh == P_H[k] - 1) begin
          nh = 0;
          lw = 1;
          nv = (nv == P_V[k] - 1) ? 0 : nv + 1;
        end else begin
          nh = nh + 1;
        end
      end else if (e) begin
        m_div[k] = m_div[k] + 1;
      end
      m_hc[k]  = nh;
      m_vc[k]  = nv;
      m_hs[k]  = nh >= P_HSP[k];
      m_vs[k]  = nv >= P_VSP[k];
      m_vid[k] = (nh >= P_HBP[k]) && (nh < P_HFP[k]) && (nv >= P_VBP[k]) && (nv < P_VFP[k]);
      m_ls[k]  = lw;
      m_fs[k]  = lw && (nv == 0);
    end
    v = {10'(m_hc[k]), 10'(m_vc[k]), m_hs[k], m_vs[k], m_vid[k], m_ls[k], m_fs[k]};
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic tick(input logic r, input logic e);
    logic [24:0] exp0, exp1;
    rst_n = r;
    en    = e;
    #1;
    if (started) begin
      check("pix_en", {31'd0, pix_en}, {31'd0, e && (m_div[0] == P_DIV[0] - 1)});
      check("pix_en_s", {31'd0, pix_en_s}, {31'd0, e && (m_div[1] == P_DIV[1] - 1)});
    end
    model_step(0, r, e);
    model_step(1, r, e);
    @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    ncyc++;
    exp0 = q0.pop_front();
    exp1 = q1.pop_front();
    check("state", {7'd0, hc, vc, hsync, vsync, vidon, line_start, frame_start}, {7'd0, exp0});
    check("state_s", {7'd0, hc_s, vc_s, hsync_s, vsync_s, vidon_s, line_start_s, frame_start_s},
          {7'd0, exp1});
  endtask

  initial begin
    int last_fs;
    int nfr;
    rst_n = 1'b0;
    en    = 1'b1;
    last_fs = -1;
    nfr = 0;
    @(negedge clk);

    // Reset with en high.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    check("rst_hc", {22'd0, hc}, 0);
    check("rst_vc", {22'd0, vc}, 0);
    check("rst_sync", {30'd0, hsync, vsync}, 0);
    check("rst_vidon", {31'd0, vidon}, 0);
    check("rst_strobes", {30'd0, line_start, frame_start}, 0);
    check("rst_pix_en", {31'd0, pix_en}, 0);

    // Divider: pix_en on alternate clocks, hc advances after each.
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 1'b1);
      check("div_hc", {22'd0, hc}, k / 2);
      check("div_pix_en", {31'd0, pix_en}, k % 2);
    end

    // Pause mid-line.
    while (m_hc[0] != 300 && ncyc < LIMIT) tick(1'b1, 1'b1);
    check("reach_hc300", m_hc[0], 300);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      check("pause_hc", {22'd0, hc}, 300);
      check("pause_pix_en", {31'd0, pix_en}, 0);
      check("pause_ls", {31'd0, line_start}, 0);
    end

    // Run to line 41, checking line decode, line wrap and small-instance frame wraps.
    while (!(m_vc[0] == 41 && m_hc[0] == 5) && ncyc < LIMIT) begin
      tick(1'b1, 1'b1);
      if (m_vc[0] == 31) begin
        if (m_hc[0] == 127) check("hsync_127", {31'd0, hsync}, 0);
        if (m_hc[0] == 128) check("hsync_128", {31'd0, hsync}, 1);
        if (m_hc[0] == 143) check("vidon_143", {31'd0, vidon}, 0);
        if (m_hc[0] == 144) check("vidon_144", {31'd0, vidon}, 1);
        if (m_hc[0] == 783) check("vidon_783", {31'd0, vidon}, 1);
        if (m_hc[0] == 784) check("vidon_784", {31'd0, vidon}, 0);
      end
      if (m_ls[0] && m_vc[0] == 41) begin
        check("lwrap_ls", {31'd0, line_start}, 1);
        check("lwrap_fs", {31'd0, frame_start}, 0);
        check("lwrap_hc", {22'd0, hc}, 0);
        check("lwrap_vc", {22'd0, vc}, 41);
      end
      if (m_fs[1]) begin
        check("fwrap_fs", {31'd0, frame_start_s}, 1);
        check("fwrap_ls", {31'd0, line_start_s}, 1);
        check("fwrap_vsync", {31'd0, vsync_s}, 0);
        check("fwrap_pos", {12'd0, hc_s, vc_s}, 0);
        if (last_fs >= 0) check("frame_period", ncyc - last_fs, SMALL_FRAME);
        last_fs = ncyc;
        nfr++;
      end
    end
    check("reach_vc41", m_vc[0], 41);
    check("frames_seen", {31'd0, nfr >= 3}, 1);

    // Reset mid-frame: back to (0,0) with no frame strobe.
    tick(1'b0, 1'b1);
    check("mrst_hc", {22'd0, hc}, 0);
    check("mrst_vc", {22'd0, vc}, 0);
    check("mrst_fs", {31'd0, frame_start}, 0);
    check("mrst_ls", {31'd0, line_start}, 0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    check("post_rst_hc", {22'd0, hc}, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
